imem_readback: RTL and testbench

Instruction-memory readback transmitter for the pattern-processor pad ring. It reads 40-bit words from the core instruction memory and sends each one out of the 8-bit port-a pads as a 7-byte frame. The frame format matches the load path byte for byte, so a host can dump memory and replay the dump unchanged to reload it. Bytes are paced by an asynchronous host strobe: the same pad used as the load shift clock, synchronised into `clk` here.

---
 rtl/imem_readback.sv | 140 ++++++++++++++
 tb/tb_imem_readback.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_readback.sv
// rtl/imem_readback.sv - instruction-memory readback transmitter, one 7-byte frame per word
// Frames mirror the load path byte for byte; bytes are paced by a synchronised host strobe.
module imem_readback #(
  parameter int ADR_WIDTH   = 10,
  parameter int DATA_WIDTH  = 40,
  parameter int FRAME_BYTES = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADR_WIDTH-1:0]  start_adr,
  input  logic [ADR_WIDTH-1:0]  word_count,
  input  logic                  host_strobe,
  output logic                  imem_read_en,
  output logic [ADR_WIDTH-1:0]  imem_read_adr,
  input  logic [DATA_WIDTH-1:0] imem_out,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  output logic                  output_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int FRAME_W = 8 * FRAME_BYTES;
  localparam int PAD_W   = FRAME_W - ADR_WIDTH - DATA_WIDTH;
  localparam int IDX_W   = $clog2(FRAME_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_SEND
  } state_t;

  state_t               state_q, state_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [ADR_WIDTH-1:0] remain_q, remain_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic                 done_q, done_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 edge_q, edge_d;
  logic                 ack_q, ack_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      remain_q   <= '0;
      frame_q    <= '0;
      byte_idx_q <= '0;
      done_q     <= 1'b0;
      // Held at 1 so a strobe already high through reset is not seen as a rising edge.
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      edge_q     <= 1'b1;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      remain_q   <= remain_d;
      frame_q    <= frame_d;
      byte_idx_q <= byte_idx_d;
      done_q     <= done_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    sync1_d = host_strobe;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    ack_d   = sync2_q & ~edge_q;
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    remain_d   = remain_q;
    frame_d    = frame_q;
    byte_idx_d = byte_idx_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          adr_d    = start_adr;
          remain_d = word_count;
          state_d  = S_READ;
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        frame_d    = {{PAD_W{1'b0}}, adr_q, imem_out};
        byte_idx_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        // Acks seen in any other state simply expire with ack_q.
        if (ack_q) begin
          if (byte_idx_q != IDX_W'(FRAME_BYTES - 1)) begin
            frame_d    = frame_q << 8;
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end else if (remain_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            adr_d    = adr_q + ADR_WIDTH'(1);
            remain_d = remain_q - ADR_WIDTH'(1);
            state_d  = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_read_en  = 1'b0;
    imem_read_adr = '0;
    tx_valid      = 1'b0;
    tx_byte       = 8'h00;
    if (state_q == S_READ) begin
      imem_read_en  = 1'b1;
      imem_read_adr = adr_q;
    end
    if (state_q == S_SEND) begin
      tx_valid = 1'b1;
      tx_byte  = frame_q[FRAME_W-1 -: 8];
    end
    busy          = (state_q != S_IDLE);
    output_enable = busy;
    done          = done_q;
  end

endmodule

// File: tb/tb_imem_readback.sv
// tb/tb_imem_readback.sv - randomized self-checking bench for imem_readback
// Expected bytes come from the frame layout; loopback re-parses them with a load-path shifter model.
module tb_imem_readback;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  start_adr;
  logic [9:0]  word_count;
  logic        host_strobe;
  logic        imem_read_en;
  logic [9:0]  imem_read_adr;
  logic [39:0] imem_out;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        output_enable;
  logic        busy;
  logic        done;

  logic [39:0] mem [1024];
  logic [7:0]  got_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          done_busy_err = 0;

  imem_readback dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_adr     (start_adr),
    .word_count    (word_count),
    .host_strobe   (host_strobe),
    .imem_read_en  (imem_read_en),
    .imem_read_adr (imem_read_adr),
    .imem_out      (imem_out),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid),
    .output_enable (output_enable),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_read_en) imem_out <= mem[imem_read_adr];
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done && busy) done_busy_err++;
  end

  task automatic strobe(input int hi, input int lo);
    host_strobe = 1'b1;
    repeat (hi) @(negedge clk);
    host_strobe = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (tx_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic dump(input logic [9:0] sa, input logic [9:0] wc, input bit inject, input string name);
    logic [55:0] word;
    logic [9:0]  a;
    logic [7:0]  exp_q [$];
    int          base;
    for (int w = 0; w <= int'(wc); w++) begin
      a    = sa + 10'(w);
      word = {6'b0, a, mem[a]};
      for (int b = 0; b < 7; b++) exp_q.push_back(word[55-8*b -: 8]);
    end
    got_q.delete();
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; start_adr = sa; word_count = wc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      wait_valid();
      n_checks++;
      if (tx_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s byte %0d: tx_valid=%b after timeout, required 1", name, i, tx_valid);
      end
      n_checks++;
      if (tx_byte !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s byte %0d: tx_byte=%h, required %h", name, i, tx_byte, exp_q[i]);
      end
      got_q.push_back(tx_byte);
      if (inject && i == 2) begin
        start = 1'b1; start_adr = 10'h100; word_count = 10'd5;
        @(negedge clk);
        start = 1'b0;
      end
      strobe(3, 3);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL %s done pulses: got %0d, required 1", name, done_cnt - base);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy after done: got %b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_adr = '0; word_count = '0; host_strobe = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_byte, tx_valid, imem_read_en, imem_read_adr, busy, output_enable, done} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset outputs: byte=%h v=%b ren=%b radr=%h busy=%b oe=%b done=%b, required all 0",
               tx_byte, tx_valid, imem_read_en, imem_read_adr, busy, output_enable, done);
    end
    // Strobe held high across reset release must not advance the first frame.
    reset = 1'b0; start = 1'b1; start_adr = 10'h12A; word_count = 10'd0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (imem_read_en !== 1'b1 || imem_read_adr !== 10'h12A) begin
      n_fail++;
      $display("FAIL reset read strobe: en=%b adr=%h, required 1 12a", imem_read_en, imem_read_adr);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'h01) begin
      n_fail++;
      $display("FAIL reset strobe-high no ack: v=%b byte=%h, required 1 01", tx_valid, tx_byte);
    end
    host_strobe = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_word();
    mem[10'h005] = 40'h12_3456_789A;
    dump(10'h005, 10'd0, 1'b0, "single");
  endtask

  task automatic test_wrap();
    mem[10'h3FF] = 40'hAA_0000_0001;
    mem[10'h000] = 40'h55_0000_0002;
    dump(10'h3FF, 10'd1, 1'b0, "wrap");
  endtask

  task automatic test_strobe_pacing();
    int base;
    base = done_cnt;
    strobe(3, 3);
    host_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; start_adr = 10'h0C3; word_count = 10'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL pacing early ack: v=%b byte=%h, required 1 00", tx_valid, tx_byte);
    end
    host_strobe = 1'b0;
    repeat (3) @(negedge clk);
    strobe(20, 0);
    n_checks++;
    if (tx_byte !== 8'hC3) begin
      n_fail++;
      $display("FAIL pacing long strobe: byte=%h, required c3", tx_byte);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (tx_byte !== 8'hC3) begin
      n_fail++;
      $display("FAIL pacing after release: byte=%h, required c3", tx_byte);
    end
    for (int i = 0; i < 5; i++) strobe(3, 3);
    n_checks++;
    if (tx_byte !== mem[10'h0C3][7:0]) begin
      n_fail++;
      $display("FAIL pacing last byte: byte=%h, required %h", tx_byte, mem[10'h0C3][7:0]);
    end
    strobe(3, 3);
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - base !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pacing completion: done pulses=%0d busy=%b, required 1 0", done_cnt - base, busy);
    end
  endtask

  task automatic test_start_busy();
    dump(10'($urandom_range(0, 1023)), 10'd1, 1'b1, "start_busy");
  endtask

  task automatic test_reset_mid();
    logic [9:0] sa;
    int         base;
    sa   = 10'($urandom_range(0, 1023));
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; start_adr = sa; word_count = 10'd2;
    @(negedge clk);
    start = 1'b0;
    wait_valid();
    for (int i = 0; i < 3; i++) strobe(3, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || output_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: v=%b busy=%b oe=%b, required 0 0 0", tx_valid, busy, output_enable);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt !== base) begin
      n_fail++;
      $display("FAIL reset_mid done: pulses=%0d, required 0", done_cnt - base);
    end
    dump(sa + 10'd7, 10'd0, 1'b0, "after_reset");
  endtask

  task automatic test_loopback();
    logic [9:0]  sa;
    logic [55:0] shreg;
    sa = 10'($urandom_range(1018, 1023));
    dump(sa, 10'd3, 1'b0, "loopback");
    n_checks++;
    if (got_q.size() !== 28) begin
      n_fail++;
      $display("FAIL loopback byte count: got %0d, required 28", got_q.size());
    end
    for (int w = 0; w < got_q.size() / 7; w++) begin
      shreg = '0;
      for (int b = 0; b < 7; b++) shreg = {shreg[47:0], got_q[7*w + b]};
      n_checks++;
      if (shreg[49:40] !== 10'((int'(sa) + w) % 1024) || shreg[39:0] !== mem[shreg[49:40]]) begin
        n_fail++;
        $display("FAIL loopback word %0d: adr=%h data=%h, required adr=%h data=%h", w,
                 shreg[49:40], shreg[39:0], 10'((int'(sa) + w) % 1024), mem[10'((int'(sa) + w) % 1024)]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++)
      dump(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 3)), 1'b0, "random");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {8'($urandom), 32'($urandom)};
    test_reset();
    test_single_word();
    test_wrap();
    test_strobe_pacing();
    test_start_busy();
    test_reset_mid();
    test_loopback();
    test_random();
    n_checks++;
    if (done_busy_err !== 0) begin
      n_fail++;
      $display("FAIL done with busy: %0d cycles had done=1 busy=1, required 0", done_busy_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
